calc_alu_seq: RTL and testbench

Multi-cycle arithmetic sequencer for the 16-bit signed calculator datapath. gencon hands it two two's-complement operands and a one-hot operator, then pulses start. The block runs add/sub in a single execute cycle and multiply as a 16-iteration shift-add loop. It returns a sign-magnitude result in the display format (bit15 = sign, [14:0] = magnitude) with overflow and error flags, and handshakes back to gencon through busy/done.

---
 rtl/calc_pkg.sv | 20 ++
 rtl/shift_add_mul.sv | 58 +++++
 rtl/calc_alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_calc_alu_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator arithmetic sequencer.
// Holds the one-hot operator codes, the sequencer state encoding and the
// largest magnitude representable in the sign-magnitude display format.
package calc_pkg;

    localparam logic [2:0]  OP_ADD  = 3'b001;
    localparam logic [2:0]  OP_SUB  = 3'b010;
    localparam logic [2:0]  OP_MUL  = 3'b100;

    localparam logic [14:0] MAG_MAX = 15'h7FFF;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        FMT,
        DONE
    } alu_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned shift-add multiplier, one partial product per step.
//
// Ports:
//   clk        system clock
//   nRST       synchronous active-low reset (clears accumulator and counter)
//   load       capture mcand_in/mplier_in, clear accumulator and counter
//   step       perform one iteration: acc += mcand << cnt when mplier[cnt]
//   mcand_in   unsigned multiplicand magnitude
//   mplier_in  unsigned multiplier magnitude
//   product    accumulator (final product after WIDTH steps)
//   last       high while the counter sits on the final iteration
module shift_add_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] partial;

    assign partial = {{WIDTH{1'b0}}, mcand} << cnt;
    assign product = acc;
    assign last    = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!nRST) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= mcand_in;
            mplier <= mplier_in;
            cnt    <= '0;
        end else if (step) begin
            if (mplier[cnt]) begin
                acc <= acc + partial;
            end
            // Wraps back to zero on the final step, leaving it ready for reuse.
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/calc_alu_seq.sv
// Multi-cycle arithmetic sequencer for the signed calculator datapath.
// Accepts two two's-complement operands and a one-hot operator on start,
// runs add/sub in one execute cycle or multiply as a WIDTH-step shift-add
// loop, and returns a sign-magnitude result (MSB = sign) with overflow and
// illegal-operator flags.
//
// Ports:
//   clk        system clock
//   nRST       synchronous active-low reset
//   start      request, sampled only in IDLE
//   operand_a  first operand, two's complement
//   operand_b  second operand, two's complement
//   op         one-hot operator: 001 add, 010 sub (a-b), 100 mul
//   busy       high in LOAD/EXEC/FMT
//   done       one-cycle pulse when result/flags are valid
//   result     sign-magnitude result, held until the next accepted start
//   overflow   true magnitude exceeded the representable maximum
//   op_error   op was not one of the three legal codes
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             op_error
);

    localparam int                 MAG_W     = WIDTH - 1;
    localparam logic [2*WIDTH-1:0] MAG_LIMIT = (2*WIDTH)'(MAG_MAX);

    alu_state_t state, state_nxt;

    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_q;
    logic [2:0]              op_q;
    logic signed [WIDTH:0]   sum_q;
    logic                    psign_q;

    logic [WIDTH:0]          sum_abs;
    logic [2*WIDTH-1:0]      product;
    logic                    mul_last;
    logic                    mul_load;
    logic                    mul_step;
    logic                    is_mul;
    logic                    op_legal;

    logic                    fmt_sign;
    logic [2*WIDTH-1:0]      fmt_mag;
    logic [WIDTH-1:0]        fmt_res;
    logic                    fmt_ovf;

    // Unsigned magnitude of a two's-complement value; the most negative
    // value maps onto 2^(WIDTH-1), which still fits the unsigned width.
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
        return v[WIDTH-1] ? unsigned'(-v) : unsigned'(v);
    endfunction

    // Sign-magnitude packing with saturation; returns {overflow, result}.
    // Zero never carries a sign bit.
    function automatic logic [WIDTH:0] sm_format(input logic sign,
                                                 input logic [2*WIDTH-1:0] mag);
        logic [WIDTH:0] r;
        if (mag == '0) begin
            r = '0;
        end else if (mag > MAG_LIMIT) begin
            r = {1'b1, sign, (SATURATE ? MAG_MAX : mag[MAG_W-1:0])};
        end else begin
            r = {1'b0, sign, mag[MAG_W-1:0]};
        end
        return r;
    endfunction

    assign is_mul   = (op_q == OP_MUL);
    assign op_legal = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);
    assign sum_abs  = sum_q[WIDTH] ? unsigned'(-sum_q) : unsigned'(sum_q);
    assign mul_load = (state == LOAD);
    assign mul_step = (state == EXEC) && is_mul;

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .nRST      (nRST),
        .load      (mul_load),
        .step      (mul_step),
        .mcand_in  (abs_mag(a_q)),
        .mplier_in (abs_mag(b_q)),
        .product   (product),
        .last      (mul_last)
    );

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (!is_mul || mul_last) begin
                    state_nxt = FMT;
                end
            end
            FMT: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture stage: operands and operator frozen at acceptance.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_q  <= operand_a;
            b_q  <= operand_b;
            op_q <= op;
        end
        // Load stage: 17-bit signed sum/difference and product sign.
        if (state == LOAD) begin
            if (op_q == OP_SUB) begin
                sum_q <= $signed({a_q[WIDTH-1], a_q}) - $signed({b_q[WIDTH-1], b_q});
            end else begin
                sum_q <= $signed({a_q[WIDTH-1], a_q}) + $signed({b_q[WIDTH-1], b_q});
            end
            psign_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
        end
    end

    always_comb begin
        fmt_sign = 1'b0;
        fmt_mag  = '0;
        if (op_q == OP_MUL) begin
            fmt_sign = psign_q;
            fmt_mag  = product;
        end else if (op_q == OP_ADD || op_q == OP_SUB) begin
            fmt_sign = sum_q[WIDTH];
            fmt_mag  = (2*WIDTH)'(sum_abs);
        end
        {fmt_ovf, fmt_res} = sm_format(fmt_sign, fmt_mag);
    end

    // Output stage: flags and result registered, done trails DONE by a cycle.
    always_ff @(posedge clk) begin
        if (!nRST) begin
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            op_error <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == IDLE && start) begin
                overflow <= 1'b0;
                op_error <= 1'b0;
            end
            if (state == EXEC && !op_legal) begin
                op_error <= 1'b1;
            end
            if (state == FMT) begin
                result   <= fmt_res;
                overflow <= fmt_ovf;
            end
        end
    end

endmodule

// File: tb/tb_calc_alu_seq.sv
// Scoreboard bench for calc_alu_seq: a saturating and a wrapping instance
// share stimulus; each has its own expected-response queue drained by a
// monitor on every done pulse.
module tb_calc_alu_seq;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        nRST;
    logic        start;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [2:0]  op;

    logic [1:0]       busy_v;
    logic [1:0]       done_v;
    logic [1:0]       ovf_v;
    logic [1:0]       err_v;
    logic [1:0][15:0] res_v;

    always #5 clk = ~clk;

    calc_alu_seq #(.WIDTH(16), .SATURATE(1'b1)) dut_sat (
        .clk       (clk),
        .nRST      (nRST),
        .start     (start),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op        (op),
        .busy      (busy_v[0]),
        .done      (done_v[0]),
        .result    (res_v[0]),
        .overflow  (ovf_v[0]),
        .op_error  (err_v[0])
    );

    calc_alu_seq #(.WIDTH(16), .SATURATE(1'b0)) dut_raw (
        .clk       (clk),
        .nRST      (nRST),
        .start     (start),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op        (op),
        .busy      (busy_v[1]),
        .done      (done_v[1]),
        .result    (res_v[1]),
        .overflow  (ovf_v[1]),
        .op_error  (err_v[1])
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] r_sat;
        logic [15:0] r_raw;
        logic        ovf;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        err;
        int          due;
        int          busy;
        int          id;
    } item_t;

    item_t q0[$];
    item_t q1[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    busy_cnt[2];
    vec_t  vecs[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", nm, id, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [2:0] o, input logic [15:0] rs,
                                input logic [15:0] rr, input logic ov,
                                input logic er);
        vec_t v;
        v.a = a; v.b = b; v.op = o; v.r_sat = rs; v.r_raw = rr; v.ovf = ov; v.err = er;
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        item_t it;
        for (int d = 0; d < 2; d++) begin
            if (!nRST) begin
                busy_cnt[d] = 0;
            end else begin
                if (busy_v[d]) busy_cnt[d]++;
                if (done_v[d]) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk($sformatf("d%0d_unexpected_done", d), -1, 32'd1, 32'd0);
                    end else begin
                        if (d == 0) it = q0.pop_front();
                        else        it = q1.pop_front();
                        chk($sformatf("d%0d_result", d),   it.id, 32'(res_v[d]), 32'(it.res));
                        chk($sformatf("d%0d_overflow", d), it.id, 32'(ovf_v[d]), 32'(it.ovf));
                        chk($sformatf("d%0d_op_error", d), it.id, 32'(err_v[d]), 32'(it.err));
                        chk($sformatf("d%0d_latency", d),  it.id, 32'(cyc), 32'(it.due));
                        chk($sformatf("d%0d_busy_cycles", d), it.id, 32'(busy_cnt[d]), 32'(it.busy));
                    end
                    busy_cnt[d] = 0;
                end
            end
        end
    end

    task automatic run(input vec_t v, input int id, input bit poke);
        item_t it;
        int    lat;
        int    t;
        @(negedge clk);
        operand_a = v.a;
        operand_b = v.b;
        op        = v.op;
        start     = 1'b1;
        @(negedge clk);
        // Scramble inputs after acceptance; the captured copies must be used.
        start     = 1'b0;
        operand_a = 16'($urandom);
        operand_b = 16'($urandom);
        op        = 3'($urandom);
        lat       = (v.op == OP_MUL) ? 19 : 4;
        it.ovf    = v.ovf;
        it.err    = v.err;
        it.due    = cyc + lat;
        it.busy   = lat - 1;
        it.id     = id;
        it.res    = v.r_sat;
        q0.push_back(it);
        it.res    = v.r_raw;
        q1.push_back(it);
        if (poke) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 60) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("done_timeout_pending", id, 32'(q0.size() + q1.size()), 32'd0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        int c0;
        vecs[0]  = mk(16'd11,    16'd23,    OP_ADD, 16'h0022, 16'h0022, 1'b0, 1'b0);
        vecs[1]  = mk(16'd3,     16'd5,     OP_SUB, 16'h8002, 16'h8002, 1'b0, 1'b0);
        vecs[2]  = mk(16'h8000,  16'h7FFF,  OP_ADD, 16'h8001, 16'h8001, 1'b0, 1'b0);
        vecs[3]  = mk(16'hFFFF,  16'hFFFF,  OP_MUL, 16'h0001, 16'h0001, 1'b0, 1'b0);
        vecs[4]  = mk(16'd0,     16'hFFFB,  OP_MUL, 16'h0000, 16'h0000, 1'b0, 1'b0);
        // -12 * 3000 = -36000; 36000 = 0x8CA0, low 15 bits 0x0CA0.
        vecs[5]  = mk(16'hFFF4,  16'd3000,  OP_MUL, 16'hFFFF, 16'h8CA0, 1'b1, 1'b0);
        vecs[6]  = mk(16'd7,     16'd9,     3'b011, 16'h0000, 16'h0000, 1'b0, 1'b1);
        vecs[7]  = mk(16'h7FFF,  16'd1,     OP_ADD, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
        vecs[8]  = mk(16'h8000,  16'd1,     OP_SUB, 16'hFFFF, 16'h8001, 1'b1, 1'b0);
        vecs[9]  = mk(16'd5,     16'd5,     OP_SUB, 16'h0000, 16'h0000, 1'b0, 1'b0);
        vecs[10] = mk(16'h8000,  16'd1,     OP_MUL, 16'hFFFF, 16'h8000, 1'b1, 1'b0);
        vecs[11] = mk(16'h8000,  16'h8000,  OP_MUL, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
        vecs[12] = mk(16'd4,     16'd4,     3'b000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        vecs[13] = mk(16'd4,     16'd4,     3'b111, 16'h0000, 16'h0000, 1'b0, 1'b1);
        // 100 * -7 = -700 = sign | 0x02BC.
        vecs[14] = mk(16'd100,   16'hFFF9,  OP_MUL, 16'h82BC, 16'h82BC, 1'b0, 1'b0);
        vecs[15] = mk(16'd128,   16'd256,   OP_MUL, 16'h7FFF, 16'h0000, 1'b1, 1'b0);

        nRST      = 1'b0;
        start     = 1'b0;
        operand_a = '0;
        operand_b = '0;
        op        = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_busy", d),     0, 32'(busy_v[d]), 32'd0);
            chk($sformatf("d%0d_rst_done", d),     0, 32'(done_v[d]), 32'd0);
            chk($sformatf("d%0d_rst_result", d),   0, 32'(res_v[d]),  32'd0);
            chk($sformatf("d%0d_rst_overflow", d), 0, 32'(ovf_v[d]),  32'd0);
            chk($sformatf("d%0d_rst_op_error", d), 0, 32'(err_v[d]),  32'd0);
        end
        nRST = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run(vecs[i], i, 1'b0);
        end
        run(vecs[14], 14, 1'b1);

        // Abort a multiply just before iteration 8 executes.
        @(negedge clk);
        operand_a = 16'hFFF4;
        operand_b = 16'd3000;
        op        = OP_MUL;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0    = cyc;
        while (cyc < c0 + 9) @(negedge clk);
        nRST = 1'b0;
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_abort_busy", d),     100, 32'(busy_v[d]), 32'd0);
            chk($sformatf("d%0d_abort_done", d),     100, 32'(done_v[d]), 32'd0);
            chk($sformatf("d%0d_abort_result", d),   100, 32'(res_v[d]),  32'd0);
            chk($sformatf("d%0d_abort_overflow", d), 100, 32'(ovf_v[d]),  32'd0);
        end
        @(negedge clk);
        nRST = 1'b1;
        repeat (25) @(negedge clk);

        run(vecs[15], 15, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drain", 999, 32'(q0.size() + q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
